// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM duty sequencer slice:
//   - default parameter values (duty width, table depth, repeat width)
//   - the power-up / reset contents of the duty table
//   - the sequencer FSM state encoding
// ---------------------------------------------------------------------------
package pwm_pkg;

    localparam int R_DEFAULT       = 8;
    localparam int N_STEPS_DEFAULT = 8;
    localparam int REP_W_DEFAULT   = 4;

    // Reset contents of the duty table; any index past the first eight
    // comes up as zero so deeper tables still have a defined start.
    function automatic logic [7:0] default_duty(input int idx);
        logic [7:0] value;
        case (idx)
            0:       value = 8'hBE;
            1:       value = 8'hFF;
            2:       value = 8'h88;
            3:       value = 8'h99;
            4:       value = 8'h66;
            5:       value = 8'h33;
            6:       value = 8'h00;
            7:       value = 8'h99;
            default: value = 8'h00;
        endcase
        return value;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/duty_table.sv
// ---------------------------------------------------------------------------
// duty_table
// N_STEPS x R register file holding the duty sequence.
// One synchronous write port, one asynchronous read port. A synchronous
// active-low reset restores the default sequence from pwm_pkg.
// Ports:
//   i_clk      clock
//   i_reset    synchronous reset, active low
//   i_wr_en    write strobe
//   i_wr_addr  write index; indices >= N_STEPS are ignored
//   i_wr_data  value to write
//   i_rd_addr  read index
//   o_rd_data  table contents at i_rd_addr (combinational)
// ---------------------------------------------------------------------------
module duty_table
    import pwm_pkg::*;
#(
    parameter int R       = R_DEFAULT,
    parameter int N_STEPS = N_STEPS_DEFAULT,
    parameter int IDX_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic [R-1:0]     i_wr_data,
    input  logic [IDX_W-1:0] i_rd_addr,
    output logic [R-1:0]     o_rd_data
);

    logic [R-1:0] r_mem [N_STEPS];
    logic         w_wr_ok;
    logic         w_rd_ok;

    // Table depth need not be a power of two, so the address space can
    // reach past the last entry; those writes are dropped.
    assign w_wr_ok = i_wr_en && (int'(i_wr_addr) < N_STEPS);
    assign w_rd_ok = (int'(i_rd_addr) < N_STEPS);

    // Storage: reset reloads the defaults; a write lands on the next edge,
    // so a read in the same cycle still sees the old value.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < N_STEPS; i++) begin
                r_mem[i] <= R'(default_duty(i));
            end
        end else if (w_wr_ok) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = w_rd_ok ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/pwm_duty_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_duty_sequencer
// Supplies the duty word to the PWM comparator. Steps through a writable
// duty table, one step every (repeat_cfg+1) PWM periods, and only changes
// the duty word on the PWM period boundary.
// Ports:
//   clk         clock
//   reset       synchronous reset, active low
//   period_end  1-cycle pulse when the PWM counter wraps
//   start       1-cycle pulse: (re)start the sequence at step 0
//   stop        1-cycle pulse: abort to idle
//   pause       level: while high in RUN, period_end is ignored
//   loop_en     sampled at start: 1 = wrap forever, 0 = one-shot
//   repeat_cfg  sampled at start: periods per step minus 1
//   wr_en       table write strobe
//   wr_addr     table write index
//   wr_data     table write value
//   duty        registered duty word
//   step_idx    index of the step currently driving duty
//   busy        high in RUN or PAUSE
//   done        1-cycle pulse when a one-shot sequence finishes
// ---------------------------------------------------------------------------
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter  int R       = R_DEFAULT,
    parameter  int N_STEPS = N_STEPS_DEFAULT,
    parameter  int REP_W   = REP_W_DEFAULT,
    localparam int IDX_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             period_end,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             loop_en,
    input  logic [REP_W-1:0] repeat_cfg,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [R-1:0]     wr_data,
    output logic [R-1:0]     duty,
    output logic [IDX_W-1:0] step_idx,
    output logic             busy,
    output logic             done
);

    seq_state_t       r_state,    w_state_nxt;
    logic [R-1:0]     r_duty,     w_duty_nxt;
    logic [IDX_W-1:0] r_step,     w_step_nxt;
    logic [REP_W-1:0] r_rep,      w_rep_nxt;
    logic             r_load,     w_load_nxt;
    logic             r_loop,     w_loop_nxt;
    logic [REP_W-1:0] r_rep_lat,  w_rep_lat_nxt;
    logic             r_done,     w_done_nxt;

    logic             w_last;
    logic [IDX_W-1:0] w_step_inc;
    logic [IDX_W-1:0] w_rd_addr;
    logic [R-1:0]     w_rd_data;

    assign w_last     = (r_step == IDX_W'(N_STEPS - 1));
    assign w_step_inc = w_last ? '0 : r_step + IDX_W'(1);

    // A pending first load reads the current step; otherwise the table is
    // looked up at the step we would advance to.
    assign w_rd_addr  = r_load ? r_step : w_step_inc;

    duty_table #(
        .R       (R),
        .N_STEPS (N_STEPS),
        .IDX_W   (IDX_W)
    ) u_table (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_duty    <= '0;
            r_step    <= '0;
            r_rep     <= '0;
            r_load    <= 1'b0;
            r_loop    <= 1'b0;
            r_rep_lat <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_duty    <= w_duty_nxt;
            r_step    <= w_step_nxt;
            r_rep     <= w_rep_nxt;
            r_load    <= w_load_nxt;
            r_loop    <= w_loop_nxt;
            r_rep_lat <= w_rep_lat_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state logic. Priority is stop > start > pause > period_end.
    // A restart keeps the current duty on the output until the next
    // period boundary loads step 0, so the comparator never sees a
    // mid-period change.
    always_comb begin
        w_state_nxt   = r_state;
        w_duty_nxt    = r_duty;
        w_step_nxt    = r_step;
        w_rep_nxt     = r_rep;
        w_load_nxt    = r_load;
        w_loop_nxt    = r_loop;
        w_rep_lat_nxt = r_rep_lat;
        w_done_nxt    = 1'b0;

        if (stop) begin
            w_state_nxt = ST_IDLE;
            w_duty_nxt  = '0;
            w_step_nxt  = '0;
            w_rep_nxt   = '0;
            w_load_nxt  = 1'b0;
        end else if (start) begin
            w_state_nxt   = ST_RUN;
            w_step_nxt    = '0;
            w_rep_nxt     = '0;
            w_load_nxt    = 1'b1;
            w_loop_nxt    = loop_en;
            w_rep_lat_nxt = repeat_cfg;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (pause) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (period_end) begin
                        if (r_load) begin
                            w_duty_nxt = w_rd_data;
                            w_rep_nxt  = '0;
                            w_load_nxt = 1'b0;
                        end else if (r_rep < r_rep_lat) begin
                            w_rep_nxt = r_rep + REP_W'(1);
                        end else begin
                            w_rep_nxt = '0;
                            if (w_last && !r_loop) begin
                                w_state_nxt = ST_DONE;
                                w_duty_nxt  = '0;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_step_nxt = w_step_inc;
                                w_duty_nxt = w_rd_data;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign duty     = r_duty;
    assign step_idx = r_step;
    assign busy     = (r_state == ST_RUN) || (r_state == ST_PAUSE);
    assign done     = r_done;

endmodule
